// File: rtl/counter.sv
// counter: free-running up-counter by STEP with terminal-count flag tc (out == MAX_VALUE).
// Build option COUNTER_SATURATE_EN: hold at MAX_VALUE instead of wrapping to 0 on overflow.
module counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] STEP        = WIDTH'(1),
  parameter logic [WIDTH-1:0] MAX_VALUE   = '1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [SUM_W-1:0] sum_c;
  logic             over_c;

  // The extra sum bit keeps overflow past 2**WIDTH-1 visible to the compare.
  always_comb begin
    sum_c  = {1'b0, cnt_q} + {1'b0, STEP};
    over_c = (sum_c > {1'b0, MAX_VALUE});
    cnt_d  = sum_c[WIDTH-1:0];
    if (over_c) begin
`ifdef COUNTER_SATURATE_EN
      cnt_d = MAX_VALUE;
`else
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RESET_VALUE;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out = cnt_q;
  assign tc  = (cnt_q == MAX_VALUE);

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed timeline plus random reset/glitch stimulus for counter, checked
// against an arithmetic reference model (8-bit default instance and a 4-bit STEP=3, MAX=10 instance).
module tb_counter;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] out8;
  logic       tc8;
  logic [3:0] out4;
  logic       tc4;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  int unsigned m8 = 0;
  int unsigned m4 = 0;
  bit          m_ok = 1'b0;

  always #5 clk = ~clk;

  counter u_dut8 (
    .clk   (clk),
    .reset (reset),
    .out   (out8),
    .tc    (tc8)
  );

  counter #(
    .WIDTH       (4),
    .RESET_VALUE (4'd0),
    .STEP        (4'd3),
    .MAX_VALUE   (4'd10)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .out   (out4),
    .tc    (tc4)
  );

  function automatic int unsigned nxt(input int unsigned v, input int unsigned step,
                                      input int unsigned max);
    int unsigned s;
    s = v + step;
    if (s > max) return SAT ? max : 0;
    return s;
  endfunction

  // Reference model: reset loads 0, otherwise add STEP with wrap/saturate rule.
  always @(posedge clk) begin
    if (reset) begin
      m8   = 0;
      m4   = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      m8 = nxt(m8, 1, 255);
      m4 = nxt(m4, 3, 10);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out8"}, 32'(out8), m8);
    chk({tag, ".tc8"},  32'(tc8),  32'(m8 == 255));
    chk({tag, ".out4"}, 32'(out4), m4);
    chk({tag, ".tc4"},  32'(tc4),  32'(m4 == 10));
  endtask

  task automatic at(input time t);
    #(t - $time);
  endtask

  int unsigned seq4_wrap [5] = '{3, 6, 9, 0, 3};
  int unsigned seq4_sat  [5] = '{3, 6, 9, 10, 10};

  initial begin
    // First reset, 17..28: edge 25 loads 0.
    at(17); reset = 1'b1;
    at(26); chk("rst1.out", 32'(out8), 32'h00); chk("rst1.tc", 32'(tc8), 32'h0);
    at(28); reset = 1'b0;
    at(36); chk("cnt.35", 32'(out8), 32'h01);
    // Glitch between edges must not disturb the count.
    at(41); reset = 1'b1;
    at(44); reset = 1'b0;
    at(46); chk("glitch.45", 32'(out8), 32'h02);
    at(56); chk("cnt.55", 32'(out8), 32'h03);

    // Second reset, 57..68: edge 65 loads 0.
    at(57); reset = 1'b1;
    at(66); chk("rst2.out", 32'(out8), 32'h00); chk_model("rst2");
    at(68); reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      at(time'(66 + 10 * k));
      chk($sformatf("seq8.%0d", k), 32'(out8), 32'(k));
      if (k <= 5) chk($sformatf("seq4.%0d", k), 32'(out4), SAT ? seq4_sat[k-1] : seq4_wrap[k-1]);
      chk_model($sformatf("m.%0d", k));
    end

    // Run up to the terminal count and across it.
    for (int v = 11; v <= 253; v++) begin
      at(time'(66 + 10 * v));
      chk_model("run");
    end
    at(time'(66 + 10 * 254));
    chk("pre.out", 32'(out8), 32'hFE); chk("pre.tc", 32'(tc8), 32'h0);
    at(time'(66 + 10 * 255));
    chk("max.out", 32'(out8), 32'hFF); chk("max.tc", 32'(tc8), 32'h1);
    at(time'(66 + 10 * 256));
    chk("ovf.out", 32'(out8), SAT ? 32'hFF : 32'h00);
    chk("ovf.tc",  32'(tc8),  SAT ? 32'h1 : 32'h0);
    for (int j = 1; j <= 5; j++) begin
      at(time'(66 + 10 * (256 + j)));
      chk($sformatf("post.%0d", j), 32'(out8), SAT ? 32'hFF : 32'(j));
      chk_model("post");
    end

    // Reset out of the terminal/saturated state.
    at(2681); reset = 1'b1;
    at(2686); chk("rst3.out", 32'(out8), 32'h00); chk("rst3.tc", 32'(tc8), 32'h0);
    at(2688); reset = 1'b0;
    at(2696); chk("rst3.first", 32'(out8), 32'h01); chk_model("rst3");

    // Random reset pulses spanning edges and glitches between edges.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk_model("rand");
      reset = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      #1;
      if (!reset && ($urandom_range(0, 7) == 0)) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    @(negedge clk);
    chk_model("final");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter WIDTH, default 8: counter width in bits; legal range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: value loaded into out on reset; SHALL fit in WIDTH bits.
REQ-004 Parameter STEP, default 1: increment per clock; SHALL be 1..2**WIDTH-1.
REQ-005 Parameter MAX_VALUE, default 2**WIDTH-1: terminal count; SHALL be >= RESET_VALUE and fit in WIDTH bits.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-008 out  output  WIDTH  current count, driven directly from a register.
REQ-009 tc  output  1  terminal-count flag, high while out == MAX_VALUE; may be left unconnected.

Function
REQ-010 On every rising clk with reset low, the block SHALL update out to out + STEP, computed in WIDTH+1 bits.
REQ-011 If the WIDTH+1-bit sum exceeds MAX_VALUE, the block SHALL load 0 into out (wrap), unless COUNTER_SATURATE_EN is defined.
REQ-012 Wrap-around SHALL take exactly one clock: MAX_VALUE followed by 0 on the next edge, with no intermediate value.
REQ-013 tc SHALL be combinational from out and SHALL be high for exactly the cycle(s) in which out == MAX_VALUE.
REQ-014 out SHALL change only on rising clk edges, and each change SHALL appear one cycle after the sampling edge (latency 1).
REQ-015 No enable exists: the block SHALL count on every non-reset cycle.
REQ-016 Before the first reset edge, out SHALL be undefined; the block SHALL NOT rely on initial or power-on values.

Reset
REQ-017 On a rising clk with reset high, the block SHALL load RESET_VALUE into out, regardless of current value.
REQ-018 Reset SHALL take priority over counting, wrap and saturation.
REQ-019 Reset asserted mid-count SHALL take effect at the next rising clk only; reset pulses not spanning a rising edge SHALL have no effect.
REQ-020 After reset deasserts, the first rising edge SHALL produce RESET_VALUE + STEP.

Configuration
REQ-021 The macro COUNTER_SATURATE_EN SHALL be the only compile-time option.
REQ-022 With COUNTER_SATURATE_EN defined, when out + STEP exceeds MAX_VALUE, out SHALL hold MAX_VALUE and tc SHALL stay high until reset.
REQ-023 With COUNTER_SATURATE_EN undefined, the wrap behaviour of REQ-011 and REQ-012 SHALL apply.
REQ-024 Port list and parameter defaults SHALL be identical in both builds.

Verification
Bench setup for all scenarios: WIDTH=8, other parameters default, clk period 10 with rising edges at 5, 15, 25, ...
REQ-025 Reset high 17..28 -> out=0x00 at t=25; 0x01 at 35; 0x02 at 45; 0x03 at 55.
REQ-026 Second reset high 57..68 -> out=0x00 at 65; 0x01 at 75; increments each edge; 0x0A at 165.
REQ-027 Wrap (macro undefined): count through 0xFE, 0xFF (tc=1), then 0x00 (tc=0) on the next edge.
REQ-028 Saturate (COUNTER_SATURATE_EN defined): out reaches 0xFF, holds 0xFF with tc=1 for 5+ edges, and reset returns out to 0x00.
REQ-029 Parameter scenario WIDTH=4, STEP=3, MAX_VALUE=10 -> after reset, out sequence 3, 6, 9, 0, 3 with the macro undefined.
REQ-030 Reset glitch between edges (high 41..44) -> no change to the count sequence.
